// File: rtl/decoder_pkg.sv
// Shared mode encodings and FSM state type for the pipelined select decoder.
package decoder_pkg;

  localparam logic [1:0] MODE_ONEHOT = 2'b00;
  localparam logic [1:0] MODE_THERM  = 2'b01;
  localparam logic [1:0] MODE_SCAN   = 2'b10;
  localparam logic [1:0] MODE_RSVD   = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SINGLE = 2'd1,
    SCAN   = 2'd2
  } state_t;

endpackage

// File: rtl/decode_vec.sv
// Combinational first-beat vector: one-hot/thermometer of sel, bit 0 for scan, zero for reserved.
module decode_vec
  import decoder_pkg::*;
#(
  parameter int IN_W = 3
) (
  input  logic [IN_W-1:0]      sel,
  input  logic [1:0]           mode,
  output logic [2**IN_W-1:0]   vec
);

  localparam int OUT_W = 2**IN_W;

  always_comb begin
    vec = '0;
    case (mode)
      MODE_ONEHOT: vec = OUT_W'(1) << sel;
      MODE_THERM: begin
        for (int i = 0; i < OUT_W; i++) begin
          vec[i] = (i <= int'(sel));
        end
      end
      // A scan always starts its walk at bit 0.
      MODE_SCAN:   vec = OUT_W'(1);
      default:     vec = '0;
    endcase
  end

endmodule

// File: rtl/onehot_decoder_pipe.sv
// Registered N-to-2^N decoder (one-hot / thermometer / scan), 1-cycle latency, valid/ready both sides.
// Define DECODER_ACTLOW_EN to drive out_y active-low (inverted, reset value all ones).
module onehot_decoder_pipe
  import decoder_pkg::*;
#(
  parameter int IN_W = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_W-1:0]      in_sel,
  input  logic [1:0]           in_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2**IN_W-1:0]   out_y,
  output logic                 out_last
);

  localparam int OUT_W = 2**IN_W;

  state_t            state_q, state_d;
  logic [IN_W-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [IN_W-1:0]   tgt_q, tgt_d;
  logic [OUT_W-1:0]  y_q, y_d, first_vec;
  logic              last_q, last_d;
  logic              load;

  decode_vec #(.IN_W(IN_W)) u_decode_vec (
    .sel  (in_sel),
    .mode (in_mode),
    .vec  (first_vec)
  );

  assign out_valid = (state_q != IDLE);
  assign in_ready  = !reset && (!out_valid || (out_ready && last_q));
  assign load      = in_valid && in_ready;
  assign cnt_inc   = cnt_q + IN_W'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tgt_d   = tgt_q;
    y_d     = y_q;
    last_d  = last_q;
    if (out_valid && out_ready) begin
      if (last_q) begin
        state_d = IDLE;
        y_d     = '0;
        last_d  = 1'b0;
      end else begin
        // Only a scan has non-last beats; walk the set bit one place up.
        cnt_d  = cnt_inc;
        y_d    = y_q << 1;
        last_d = (cnt_inc == tgt_q);
      end
    end
    // A load only happens from IDLE or alongside the final beat, so it overrides.
    if (load) begin
      state_d = (in_mode == MODE_SCAN) ? SCAN : SINGLE;
      cnt_d   = '0;
      tgt_d   = in_sel;
      y_d     = first_vec;
      last_d  = (in_mode != MODE_SCAN) || (in_sel == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tgt_q   <= '0;
      y_q     <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tgt_q   <= tgt_d;
      y_q     <= y_d;
      last_q  <= last_d;
    end
  end

`ifdef DECODER_ACTLOW_EN
  assign out_y = ~y_q;
`else
  assign out_y = y_q;
`endif
  assign out_last = last_q;

endmodule

// File: tb/tb_onehot_decoder_pipe.sv
// Directed-vector bench for onehot_decoder_pipe at IN_W=3; expectations follow the active-low build when enabled.
module tb_onehot_decoder_pipe;

  localparam int IN_W  = 3;
  localparam int OUT_W = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_sel;
  logic [1:0]       in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_y;
  logic             out_last;

  int n_tests = 0;
  int n_fail  = 0;

  onehot_decoder_pipe #(.IN_W(IN_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sel    (in_sel),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  function automatic logic [OUT_W-1:0] ey(input logic [OUT_W-1:0] v);
`ifdef DECODER_ACTLOW_EN
    return ~v;
`else
    return v;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one command from IDLE; after return the first beat is visible.
  task automatic cmd(input logic [1:0] mode, input logic [IN_W-1:0] sel);
    in_valid = 1'b1;
    in_mode  = mode;
    in_sel   = sel;
    check("cmd_in_ready", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
  endtask

  logic [OUT_W-1:0] hold_y [5];
  logic             hold_l [5];
  logic             hold_r [5];
  logic             hold_ir[5];

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_sel    = '0;
    in_mode   = 2'b00;
    out_ready = 1'b0;
    step();
    step();
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_y", 32'(out_y), 32'(ey(8'h00)));
    check("rst_last", 32'(out_last), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    reset = 1'b0;
    #1;
    check("idle_in_ready", 32'(in_ready), 32'd1);

    // One-hot sel=5, single beat.
    out_ready = 1'b1;
    cmd(2'b00, 3'd5);
    check("oh5_valid", 32'(out_valid), 32'd1);
    check("oh5_y", 32'(out_y), 32'(ey(8'h20)));
    check("oh5_last", 32'(out_last), 32'd1);
    step();
    check("oh5_gone", 32'(out_valid), 32'd0);

    // Thermometer sel=3 and sel=7.
    cmd(2'b01, 3'd3);
    check("th3_y", 32'(out_y), 32'(ey(8'h0F)));
    check("th3_last", 32'(out_last), 32'd1);
    step();
    cmd(2'b01, 3'd7);
    check("th7_y", 32'(out_y), 32'(ey(8'hFF)));
    step();
    cmd(2'b01, 3'd0);
    check("th0_y", 32'(out_y), 32'(ey(8'h01)));
    step();

    // Scan sel=3, free-flowing consumer.
    cmd(2'b10, 3'd3);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("scan3_valid%0d", i), 32'(out_valid), 32'd1);
      check($sformatf("scan3_y%0d", i), 32'(out_y), 32'(ey(8'(1 << i))));
      check($sformatf("scan3_last%0d", i), 32'(out_last), 32'(i == 3));
      check($sformatf("scan3_in_ready%0d", i), 32'(in_ready), 32'(i == 3));
      step();
    end
    check("scan3_done", 32'(out_valid), 32'd0);

    // Scan sel=2 with stalls; producer noise during stalls must be ignored.
    hold_r  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    hold_y  = '{8'h01, 8'h02, 8'h02, 8'h02, 8'h04};
    hold_l  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    hold_ir = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    cmd(2'b10, 3'd2);
    for (int i = 0; i < 5; i++) begin
      out_ready = hold_r[i];
      in_valid  = (i >= 1 && i <= 3);
      in_mode   = 2'b00;
      in_sel    = 3'd6;
      #1;
      check($sformatf("hold_y%0d", i), 32'(out_y), 32'(ey(hold_y[i])));
      check($sformatf("hold_last%0d", i), 32'(out_last), 32'(hold_l[i]));
      check($sformatf("hold_in_ready%0d", i), 32'(in_ready), 32'(hold_ir[i]));
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("hold_done", 32'(out_valid), 32'd0);

    // Back-to-back one-hot commands at full throughput.
    in_valid = 1'b1;
    in_mode  = 2'b00;
    for (int i = 0; i < 3; i++) begin
      in_sel = 3'(i);
      #1;
      check($sformatf("b2b_in_ready%0d", i), 32'(in_ready), 32'd1);
      step();
      check($sformatf("b2b_valid%0d", i), 32'(out_valid), 32'd1);
      check($sformatf("b2b_y%0d", i), 32'(out_y), 32'(ey(8'(1 << i))));
      check($sformatf("b2b_last%0d", i), 32'(out_last), 32'd1);
    end
    in_valid = 1'b0;
    step();
    check("b2b_done", 32'(out_valid), 32'd0);

    // Reset during second beat of a sel=7 scan.
    cmd(2'b10, 3'd7);
    check("rs_y0", 32'(out_y), 32'(ey(8'h01)));
    step();
    check("rs_y1", 32'(out_y), 32'(ey(8'h02)));
    reset = 1'b1;
    #1;
    check("rs_in_ready", 32'(in_ready), 32'd0);
    step();
    reset = 1'b0;
    check("rs_valid", 32'(out_valid), 32'd0);
    check("rs_y", 32'(out_y), 32'(ey(8'h00)));
    check("rs_last", 32'(out_last), 32'd0);
    step();
    check("rs_no_more", 32'(out_valid), 32'd0);

    // Reserved mode: one beat, zero vector, last set.
    cmd(2'b11, 3'd5);
    check("rsvd_valid", 32'(out_valid), 32'd1);
    check("rsvd_y", 32'(out_y), 32'(ey(8'h00)));
    check("rsvd_last", 32'(out_last), 32'd1);
    step();
    check("rsvd_done", 32'(out_valid), 32'd0);

    // Scan with sel=0 is a single one-hot-of-0 beat.
    cmd(2'b10, 3'd0);
    check("scan0_y", 32'(out_y), 32'(ey(8'h01)));
    check("scan0_last", 32'(out_last), 32'd1);
    step();
    check("scan0_done", 32'(out_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/onehot_decoder_pipe.md
Name: onehot_decoder_pipe

Overview:
Parametrised, registered N-to-2^N decoder with valid/ready handshakes on both sides. It supports three output modes:
- one-hot;
- thermometer;
- multi-beat scan, which walks a single set bit from position 0 up to the selected index.

It sits between a select/command producer and per-line enable consumers in the class SoC datapath, replacing fixed-width combinational decoders where backpressure or sequencing is needed.

Parameters:
- IN_W, 3, select width; decoder output width OUT_W = 2**IN_W (derived localparam, not overridable). Legal range 1..6.

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  command valid
- in_ready  output  1  block can accept a command this cycle
- in_sel  input  IN_W  select index
- in_mode  input  2  00 one-hot, 01 thermometer, 10 scan, 11 reserved
- out_valid  output  1  out_y/out_last valid
- out_ready  input  1  consumer accepts current beat
- out_y  output  OUT_W  decoded vector
- out_last  output  1  final beat of current command

Behaviour:
- Reset:
  - Synchronous; reset sampled high at a clock edge forces out_valid=0, out_y=0, out_last=0, state=IDLE, beat counter=0 on that edge.
  - Reset mid-scan abandons the command with no further beats.
  - in_ready is low while reset is high.
- Handshakes:
  - An input transfer occurs when in_valid && in_ready.
  - An output transfer occurs when out_valid && out_ready.
  - in_ready = !reset && (!out_valid || (out_ready && out_last)), so a new command is accepted in the same cycle the final beat of the previous one leaves. This gives full throughput for single-beat modes.
- Latency: 1 cycle. A command accepted at edge k makes its first beat visible with out_valid=1 after edge k.
- out_y and out_last hold stable while out_valid && !out_ready. Producer-side changes are ignored while in_ready=0.
- States:
  - IDLE: out_valid=0. Accept → SINGLE (modes 00/01/11) or SCAN (mode 10).
  - SINGLE: one beat, out_last=1. On output transfer: new accept → SINGLE/SCAN, else → IDLE.
  - SCAN: on output transfer with out_last=0, stay in SCAN. On output transfer with out_last=1, go to SINGLE/SCAN/IDLE as for SINGLE.
- Mode 00 (one-hot): out_y = 1 << in_sel.
- Mode 01 (thermometer): out_y bits [in_sel:0] set, all others 0. in_sel=0 gives 1; in_sel=OUT_W-1 gives all ones.
- Mode 10 (scan):
  - Registers target = in_sel and beat counter cnt = 0.
  - Beat n drives out_y = 1 << cnt, with out_last = (cnt == target).
  - Each non-last output transfer increments cnt, giving in_sel+1 beats total.
  - in_sel=0 degenerates to a single beat, identical to one-hot of 0.
- Mode 11 (reserved): one beat, out_y=0, out_last=1. It is never dropped, so the consumer always sees a beat.
- No wrap-around: cnt never exceeds target ≤ OUT_W-1. The counter is IN_W bits wide.

Optional Feature:
- Macro: DECODER_ACTLOW_EN.
- When defined, out_y is driven active-low (bitwise inverted), including the reset value, which becomes all ones. Mode 11 then drives all ones.
- When undefined, out_y is active-high as described above.
- Handshake and out_last behaviour are identical in both builds.

Decomposition:
- Package decoder_pkg holds:
  - mode constants MODE_ONEHOT=2'b00, MODE_THERM=2'b01, MODE_SCAN=2'b10, MODE_RSVD=2'b11;
  - the state enum {IDLE, SINGLE, SCAN}.
- One natural sub-module: decode_vec, a purely combinational function of (sel, mode) producing the one-hot/thermometer vector. It is instantiated once for the initial beat; the scan path shifts the registered vector.

Test Plan:
- IN_W=3, mode 00, in_sel=5, out_ready=1 → one cycle later out_y=8'b0010_0000, out_last=1, out_valid=1 for exactly one cycle.
- Mode 01, in_sel=3 → out_y=8'b0000_1111. in_sel=7 → out_y=8'hFF.
- Mode 10, in_sel=3, out_ready=1 → four beats 8'h01, 8'h02, 8'h04, 8'h08, with out_last only on 8'h08. in_ready=0 during beats 1–3 and 1 during the last beat.
- Mode 10, in_sel=2, out_ready toggled 1,0,0,1,1 → beats 8'h01, 8'h02 (held 3 cycles, stable), 8'h04. No beat skipped or duplicated.
- Back-to-back mode 00 commands sel=0,1,2 with in_valid and out_ready held high → out_y 8'h01, 8'h02, 8'h04 on consecutive cycles, in_ready continuously 1.
- Reset asserted during the second beat of a mode-10 in_sel=7 scan → next cycle out_valid=0, out_y=0 (all ones with DECODER_ACTLOW_EN). Mode 11 after reset → single beat out_y=0, out_last=1.
